// File: rtl/stage5_writeback.sv
// LEGv8 writeback stage: 2-entry skid FIFO in front of the register-file write port.
// Optional `LEGV8_WB_FORWARD_EN adds a combinational forwarding lookup over pending writes.
module stage5_writeback #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_signed,
    input  logic              rf_busy,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [31:0]       wb_retired
`ifdef LEGV8_WB_FORWARD_EN
    ,
    input  logic [REG_AW-1:0] fwd_rd,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam logic [REG_AW-1:0] XZR = REG_AW'(31);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t state;
    wb_entry_t   slot0;  // head
    wb_entry_t   slot1;  // second entry, valid only in FULL
    wb_entry_t   new_entry;
    logic        push;
    logic        pop;

    // Right-aligned load data, extended from the selected field width.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] m,
                                                    input logic [1:0]        sz,
                                                    input logic              sgn);
        logic [DATA_W-1:0] r;
        case (sz)
            2'b00:   r = {{(DATA_W-8){sgn & m[7]}}, m[7:0]};
            2'b01:   r = {{(DATA_W-16){sgn & m[15]}}, m[15:0]};
            2'b10:   r = {{(DATA_W-32){sgn & m[31]}}, m[31:0]};
            default: r = m;
        endcase
        return r;
    endfunction

    assign in_ready = (state != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state != EMPTY) && !rf_busy;

    always_comb begin
        new_entry.rd   = in_rd;
        new_entry.we   = in_regwrite && (in_rd != XZR);
        new_entry.data = in_memtoreg ? load_ext(in_mem_data, in_load_size, in_load_signed)
                                     : in_alu_result;
    end

    // FIFO occupancy, write port and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            slot0      <= '0;
            slot1      <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            wb_retired <= '0;
        end else begin
            if (pop) begin
                rf_wr_en   <= slot0.we;
                rf_wr_addr <= slot0.rd;
                rf_wr_data <= slot0.data;
                wb_retired <= wb_retired + 32'd1;
            end else begin
                rf_wr_en <= 1'b0;
            end

            case (state)
                EMPTY: begin
                    if (push) begin
                        slot0 <= new_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b11: slot0 <= new_entry;
                        2'b10: begin
                            slot1 <= new_entry;
                            state <= FULL;
                        end
                        2'b01: state <= EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        slot0 <= slot1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef LEGV8_WB_FORWARD_EN
    wb_entry_t tail;
    logic      pend;

    assign tail = (state == FULL) ? slot1 : slot0;
    assign pend = (state != EMPTY);

    // Youngest match wins: tail, then head, then the write in flight.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rd != XZR) begin
            if (pend && tail.we && (tail.rd == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = tail.data;
            end else if (pend && slot0.we && (slot0.rd == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = slot0.data;
            end else if (rf_wr_en && (rf_wr_addr == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wr_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage5_writeback.sv
// Bench for stage5_writeback: queue-based reference model checked every cycle, plus directed literals.
module tb_stage5_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_data;
    logic [1:0]  in_load_size;
    logic        in_load_signed;
    logic        rf_busy;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic [31:0] wb_retired;
`ifdef LEGV8_WB_FORWARD_EN
    logic [4:0]  fwd_rd;
    logic        fwd_hit;
    logic [63:0] fwd_data;
`endif

    always #5 clk = ~clk;

    stage5_writeback #(.DATA_W(64), .REG_AW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_regwrite    (in_regwrite),
        .in_memtoreg    (in_memtoreg),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .rf_busy        (rf_busy),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .wb_retired     (wb_retired)
`ifdef LEGV8_WB_FORWARD_EN
        ,
        .fwd_rd         (fwd_rd),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    logic [31:0] exp_ret;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [63:0] ref_ext(input logic [63:0] mem, input logic [1:0] size,
                                            input logic sgn);
        int          bits = 8 << size;
        logic [63:0] mask = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
        logic [63:0] v    = mem & mask;
        if (sgn && bits < 64 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare outputs with the model, drive inputs, advance the model past the next edge.
    task automatic step(input logic v, input logic [4:0] rd, input logic rw, input logic mt,
                        input logic [63:0] alu, input logic [63:0] mem, input logic [1:0] sz,
                        input logic sg, input logic busy);
        logic push, pop;
        ent_t e;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
        chk("rf_wr_en", 64'(rf_wr_en), 64'(exp_en));
        chk("rf_wr_addr", 64'(rf_wr_addr), 64'(exp_addr));
        chk("rf_wr_data", rf_wr_data, exp_data);
        chk("wb_retired", 64'(wb_retired), 64'(exp_ret));
        in_valid = v; in_rd = rd; in_regwrite = rw; in_memtoreg = mt;
        in_alu_result = alu; in_mem_data = mem; in_load_size = sz; in_load_signed = sg;
        rf_busy = busy;
`ifdef LEGV8_WB_FORWARD_EN
        begin
            logic hit; logic [63:0] d;
            hit = 1'b0; d = '0;
            #1;
            if (fwd_rd != 5'd31) begin
                for (int i = q.size() - 1; i >= 0 && !hit; i--)
                    if (q[i].we && q[i].rd == fwd_rd) begin hit = 1'b1; d = q[i].data; end
                if (!hit && exp_en && exp_addr == fwd_rd) begin hit = 1'b1; d = exp_data; end
            end
            chk("fwd_hit", 64'(fwd_hit), 64'(hit));
            chk("fwd_data", fwd_data, d);
        end
`endif
        push = v && (q.size() != 2);
        pop  = (q.size() > 0) && !busy;
        if (pop) begin
            e = q.pop_front();
            exp_en = e.we; exp_addr = e.rd; exp_data = e.data;
            exp_ret = exp_ret + 32'd1;
        end else begin
            exp_en = 1'b0;
        end
        if (push) begin
            e.rd = rd; e.we = rw && (rd != 5'd31);
            e.data = mt ? ref_ext(mem, sz, sg) : alu;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic busy);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0, busy);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_alu_result = '0; in_mem_data = '0; in_load_size = '0; in_load_signed = 1'b0;
        rf_busy = 1'b0;
`ifdef LEGV8_WB_FORWARD_EN
        fwd_rd = 5'd0;
`endif
        exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_ret = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", 64'(rf_wr_en), 64'd0);
        chk("rst_addr", 64'(rf_wr_addr), 64'd0);
        chk("rst_data", rf_wr_data, 64'd0);
        chk("rst_ret", 64'(wb_retired), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Single ALU write appears after E+1.
        step(1'b1, 5'd3, 1'b1, 1'b0, 64'h1234, 64'd0, 2'd0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("alu_en", 64'(rf_wr_en), 64'd1);
        chk("alu_addr", 64'(rf_wr_addr), 64'd3);
        chk("alu_data", rf_wr_data, 64'h1234);
        chk("alu_ret", 64'(wb_retired), 64'd1);
        idle(1, 1'b0);
        chk("alu_pulse", 64'(rf_wr_en), 64'd0);

        // Load extension, back-to-back.
        step(1'b1, 5'd7, 1'b1, 1'b1, 64'd0, 64'h80, 2'b00, 1'b1, 1'b0);
        step(1'b1, 5'd8, 1'b1, 1'b1, 64'd0, 64'h80, 2'b00, 1'b0, 1'b0);
        step(1'b1, 5'd9, 1'b1, 1'b1, 64'd0, 64'h8000_0000, 2'b10, 1'b1, 1'b0);
        chk("ext_sb", rf_wr_data, 64'hFFFF_FFFF_FFFF_FF80);
        idle(1, 1'b0);
        chk("ext_ub", rf_wr_data, 64'h80);
        idle(1, 1'b0);
        chk("ext_sw", rf_wr_data, 64'hFFFF_FFFF_8000_0000);
        idle(2, 1'b0);

        // XZR and non-writing entries retire without a write strobe.
        step(1'b1, 5'd31, 1'b1, 1'b0, 64'hDEAD, 64'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 1'b0, 1'b0, 64'hBEEF, 64'd0, 2'd0, 1'b0, 1'b0);
        chk("xzr_en", 64'(rf_wr_en), 64'd0);
        idle(3, 1'b0);
        chk("xzr_ret", 64'(wb_retired), 64'd6);

        // Backpressure fills the FIFO, then drains in order.
        step(1'b1, 5'd1, 1'b1, 1'b0, 64'h11, 64'd0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 5'd2, 1'b1, 1'b0, 64'h22, 64'd0, 2'd0, 1'b0, 1'b1);
        idle(1, 1'b1);
        chk("bp_full", 64'(in_ready), 64'd0);
        idle(2, 1'b0);
        chk("bp_w1_addr", 64'(rf_wr_addr), 64'd1);
        chk("bp_w1_data", rf_wr_data, 64'h11);
        chk("bp_ready", 64'(in_ready), 64'd1);
        idle(1, 1'b0);
        chk("bp_w2_en", 64'(rf_wr_en), 64'd1);
        chk("bp_w2_addr", 64'(rf_wr_addr), 64'd2);
        idle(2, 1'b0);

`ifdef LEGV8_WB_FORWARD_EN
        step(1'b1, 5'd4, 1'b1, 1'b0, 64'hA, 64'd0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 5'd4, 1'b1, 1'b0, 64'hB, 64'd0, 2'd0, 1'b0, 1'b1);
        fwd_rd = 5'd4;
        idle(1, 1'b1);
        chk("fwd_tail_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_tail_data", fwd_data, 64'hB);
        fwd_rd = 5'd31;
        #1;
        chk("fwd_xzr_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_xzr_data", fwd_data, 64'd0);
        idle(4, 1'b0);
`endif

        // Reset while FULL and blocked.
        step(1'b1, 5'd10, 1'b1, 1'b0, 64'h10, 64'd0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 5'd11, 1'b1, 1'b0, 64'h20, 64'd0, 2'd0, 1'b0, 1'b1);
        idle(1, 1'b1);
        #1 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("mrst_en", 64'(rf_wr_en), 64'd0);
        chk("mrst_addr", 64'(rf_wr_addr), 64'd0);
        chk("mrst_data", rf_wr_data, 64'd0);
        chk("mrst_ret", 64'(wb_retired), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        q.delete();
        exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_ret = '0;
        #1 rst_n = 1'b1;
        idle(5, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rd;
            rd = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom % 8);
`ifdef LEGV8_WB_FORWARD_EN
            fwd_rd = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 8);
`endif
            step(($urandom % 10) < 7, rd, 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
                 ($urandom % 10) < 3);
        end
        idle(4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage5_writeback.md
Name: stage5_writeback

Overview:
- Writeback stage of the LEGv8 pipeline; the write side of the register file that the decode stage reads.
- Accepts MEM/WB results through a valid/ready handshake and selects the ALU result or the load data.
- Sign- or zero-extends load data.
- Buffers up to 2 results in a skid FIFO while the register-file write port is blocked.
- Drives a registered write port (rf_wr_en/addr/data) and counts retired instructions.

Parameters:
- DATA_W, 64 (`LEGV8_INTEGER_SZ), register/data width.
- REG_AW, 5 ($clog2(`LEGV8_REGISTER_COUNT)), register index width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM/WB entry valid
- in_ready  out  1  stage can accept an entry
- in_rd  in  REG_AW  destination register
- in_regwrite  in  1  entry writes a register
- in_memtoreg  in  1  1 = load data, 0 = ALU result
- in_alu_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  raw load data, right-aligned
- in_load_size  in  2  00 byte, 01 half, 10 word, 11 dword
- in_load_signed  in  1  1 = sign-extend, 0 = zero-extend
- rf_busy  in  1  write port unavailable this cycle
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  REG_AW  write index
- rf_wr_data  out  DATA_W  write data
- wb_retired  out  32  count of retired entries

Behaviour:
- Reset (async, rst_n low): FIFO count = 0; rf_wr_en = 0; rf_wr_addr = 0; rf_wr_data = 0; wb_retired = 0. Buffered entries are discarded; nothing is written after reset.
- FIFO states, from count: EMPTY (0), ONE (1), FULL (2). in_ready = (count != 2), combinational from state only.
- Accept: on the edge where in_valid && in_ready, push {rd, we, data}.
  - we = in_regwrite && (in_rd != 31); X31/XZR is never written.
  - data = in_memtoreg ? ext(in_mem_data) : in_alu_result.
  - ext: take the low 8/16/32/64 bits per in_load_size; fill upper bits with the MSB of the field if in_load_signed, else zeros. Dword ignores in_load_signed.
- Pop: on every edge where count > 0 and rf_busy == 0:
  - pop the head;
  - rf_wr_en <= head.we; rf_wr_addr <= head.rd; rf_wr_data <= head.data;
  - wb_retired <= wb_retired + 1, including non-writing entries; wraps 0xFFFFFFFF -> 0.
- Otherwise rf_wr_en <= 0. rf_wr_addr and rf_wr_data hold their previous values.
- rf_wr_en is high for exactly one cycle per write.
- Latency: an entry accepted at edge E into EMPTY with rf_busy low appears on rf_wr_* after edge E+1.
- Simultaneous push and pop in ONE: count stays 1, and the new entry becomes the head.
- Simultaneous push and pop in EMPTY is impossible; push happens first.
- FULL: in_ready = 0. A pop in FULL makes in_ready = 1 only in the following cycle; there is no same-cycle bypass.
- Writes leave in strict acceptance order.
- rf_busy high holds all FIFO contents and wb_retired.
- in_* fields are ignored when in_valid == 0.

Optional Feature:
- Macro: LEGV8_WB_FORWARD_EN.
- When defined, add ports:
  - fwd_rd  in  REG_AW
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- Forwarding logic is combinational. fwd_hit = 1 if fwd_rd != 31 and fwd_rd matches a pending write. Priority, youngest first:
  1. FIFO tail entry (we = 1);
  2. FIFO head entry (we = 1);
  3. rf_wr_* while rf_wr_en = 1.
- fwd_data is the data of the highest-priority match; it is 0 when fwd_hit = 0.
- When undefined: the ports are absent, no comparators are generated, and decode must stall on hazards.

Test Plan:
- Single ALU write: accept rd=3, alu=0x1234, memtoreg=0, rf_busy=0 -> one cycle of rf_wr_en with addr 3, data 0x1234 after edge E+1; wb_retired=1.
- Load extension: mem_data=0x80 with size=00, signed=1 -> rf_wr_data=0xFFFFFFFFFFFFFF80. With signed=0 -> 0x80. mem_data=0x8000_0000, size=10, signed=1 -> 0xFFFFFFFF80000000.
- XZR/no-write: rd=31 regwrite=1, then rd=5 regwrite=0 -> rf_wr_en never asserts; wb_retired increments by 2.
- Backpressure: rf_busy=1, push rd=1 (0x11), rd=2 (0x22) -> in_ready=0 with count 2. Release rf_busy -> writes to r1 then r2 on consecutive cycles; in_ready=1 after the first pop.
- Reset mid-operation: FULL FIFO with rf_busy=1, pulse rst_n low -> all outputs 0 immediately; after release, no stale writes.
- Forwarding (LEGV8_WB_FORWARD_EN): FIFO holds r4=0xA (head) and r4=0xB (tail), fwd_rd=4 -> fwd_hit=1, fwd_data=0xB. fwd_rd=31 -> fwd_hit=0.
